// File: rtl/phase_en_pkg.sv
`default_nettype none
// ============================================================================
// phase_en_pkg : MODE encoding and tap placement shared by phase_en_gen.
// Rev 1.0
// ============================================================================
package phase_en_pkg;

  typedef enum logic [1:0] {
    MODE_FILL = 2'd0,
    MODE_WALK = 2'd1,
    MODE_RING = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  // Taps are spaced evenly along the chain, tap 0 sitting on bit 0.
  function automatic int tap_index(input int k, input int len, input int nch);
    return (k * len) / nch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_en_tap.sv
`default_nettype none
// ============================================================================
// phase_en_tap : one registered tap enable plus optional rising-edge pulse.
// Macro PHASE_EN_GEN_EDGE_EN compiles in the pulse; otherwise enp is 0.
// Rev 1.0
// ============================================================================
module phase_en_tap (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  input  logic tap_bit,
  output logic en,
  output logic enp
);

  logic r_en;
  logic w_en_next;

  assign w_en_next = hold ? r_en : tap_bit;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_en <= 1'b0;
    end else begin
      r_en <= w_en_next;
    end
  end

  assign en = r_en;

`ifdef PHASE_EN_GEN_EDGE_EN
  logic r_enp;

  // r_en still holds the previous enable here, so the pulse lands with the rise.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_enp <= 1'b0;
    end else begin
      r_enp <= w_en_next & ~r_en;
    end
  end

  assign enp = r_enp;
`else
  assign enp = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/phase_en_gen.sv
`default_nettype none
// ============================================================================
// phase_en_gen : shift-chain sequencer (FILL/WALK/RING/HOLD) with NCH tap enables.
// Macro PHASE_EN_GEN_EDGE_EN enables the ENP rising-edge pulses.
// Rev 1.0
// ============================================================================
module phase_en_gen
  import phase_en_pkg::*;
#(
  parameter int LEN = 20,
  parameter int NCH = 4
) (
  input  logic                       C,
  input  logic                       R,
  input  logic                       E,
  input  logic [1:0]                 MODE,
  output logic [LEN-1:0]             SH,
  output logic [NCH-1:0]             EN,
  output logic [NCH-1:0]             ENP,
  output logic [$clog2(LEN+1)-1:0]   CNT,
  output logic                       DONE
);

  localparam int              c_cw       = $clog2(LEN + 1);
  localparam logic [c_cw-1:0] c_cnt_max  = c_cw'(LEN);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(LEN - 1);
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

  mode_e           w_mode;
  mode_e           r_mode_prev;
  logic [LEN-1:0]  r_sh;
  logic [LEN-1:0]  w_sh_next;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_next;
  logic [c_cw-1:0] w_cnt_sat;
  logic [c_cw-1:0] w_cnt_wrap;
  logic            r_done;
  logic            w_done_next;

  assign w_mode = mode_e'(MODE);

  always_comb begin
    w_sh_next   = r_sh;
    w_cnt_next  = r_cnt;
    w_done_next = r_done;
    w_cnt_sat   = (r_cnt >= c_cnt_max)  ? c_cnt_max : r_cnt + c_cnt_one;
    w_cnt_wrap  = (r_cnt >= c_cnt_last) ? '0        : r_cnt + c_cnt_one;
    case (w_mode)
      MODE_FILL: begin
        w_sh_next   = {r_sh[LEN-2:0], 1'b1};
        w_cnt_next  = w_cnt_sat;
        w_done_next = r_done | (&w_sh_next);
      end
      MODE_WALK: begin
        if ((r_sh == '0) && !r_done) begin
          w_sh_next = {{(LEN-1){1'b0}}, 1'b1};
        end else begin
          w_sh_next = {r_sh[LEN-2:0], 1'b0};
        end
        w_cnt_next  = w_cnt_sat;
        w_done_next = r_done | r_sh[LEN-1];
      end
      MODE_RING: begin
        if (r_sh == '0) begin
          w_sh_next = {{(LEN-1){1'b0}}, 1'b1};
        end else begin
          w_sh_next = {r_sh[LEN-2:0], r_sh[LEN-1]};
        end
        w_cnt_next  = w_cnt_wrap;
        // Wrap pulse, suppressed on the edge that switches into RING.
        w_done_next = (r_mode_prev == MODE_RING) && r_sh[LEN-1];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R || !E) begin
      r_sh        <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_mode_prev <= MODE_FILL;
    end else begin
      r_sh        <= w_sh_next;
      r_cnt       <= w_cnt_next;
      r_done      <= w_done_next;
      r_mode_prev <= w_mode;
    end
  end

  assign SH   = r_sh;
  assign CNT  = r_cnt;
  assign DONE = r_done;

  for (genvar k = 0; k < NCH; k++) begin : g_tap
    localparam int c_tap = tap_index(k, LEN, NCH);

    phase_en_tap u_tap (
      .clk     (C),
      .rst     (R),
      .clr     (~E),
      .hold    (w_mode == MODE_HOLD),
      .tap_bit (r_sh[c_tap]),
      .en      (EN[k]),
      .enp     (ENP[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_en_gen.sv
`default_nettype none
// ============================================================================
// tb_phase_en_gen : directed scenarios plus random R/E/MODE against a model.
// Rev 1.0
// ============================================================================
module tb_phase_en_gen;
  import phase_en_pkg::*;

  localparam int LEN = 20;
  localparam int NCH = 4;

  logic        C = 1'b0;
  logic        R;
  logic        E;
  logic [1:0]  MODE;
  logic [19:0] SH;
  logic [3:0]  EN;
  logic [3:0]  ENP;
  logic [4:0]  CNT;
  logic        DONE;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [19:0] m_sh;
  logic [3:0]  m_en;
  logic [3:0]  m_enp;
  int          m_cnt;
  logic        m_done;
  int          m_prev;
  logic        m_cnt_known;

  phase_en_gen #(.LEN(LEN), .NCH(NCH)) dut (
    .C    (C),
    .R    (R),
    .E    (E),
    .MODE (MODE),
    .SH   (SH),
    .EN   (EN),
    .ENP  (ENP),
    .CNT  (CNT),
    .DONE (DONE)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: chain as a 20-bit number, doubling = shift, top bit / 2^19 = wrap.
  task automatic model_update(input bit r, input bit e, input logic [1:0] md);
    logic [19:0] old;
    logic [3:0]  new_en;
    if (r || !e) begin
      m_sh = '0; m_en = '0; m_enp = '0; m_cnt = 0; m_done = 1'b0;
      m_prev = -1; m_cnt_known = 1'b1;
      return;
    end
    old = m_sh;
    case (md)
      2'd0: begin
        m_sh  = 20'(old * 2 + 1);
        m_cnt = (m_cnt < LEN) ? m_cnt + 1 : LEN;
        if (m_sh == 20'hFFFFF) m_done = 1'b1;
      end
      2'd1: begin
        if (old == 0 && !m_done) m_sh = 20'd1;
        else m_sh = 20'(old * 2);
        if (old >= 2**19) m_done = 1'b1;
        m_cnt_known = 1'b0;
      end
      2'd2: begin
        if (old == 0) m_sh = 20'd1;
        else m_sh = 20'(old * 2 + old / (2**19));
        if (m_cnt >= LEN) m_cnt_known = 1'b0;
        m_cnt  = (m_cnt + 1) % LEN;
        m_done = (m_prev == 2) && (old >= 2**19);
      end
      default: ;
    endcase
    if (md != 2'd3) begin
      for (int k = 0; k < NCH; k++) new_en[k] = old[k * (LEN / NCH)];
`ifdef PHASE_EN_GEN_EDGE_EN
      m_enp = new_en & ~m_en;
`else
      m_enp = '0;
`endif
      m_en = new_en;
    end else begin
      m_enp = '0;
    end
    m_prev = int'(md);
  endtask

  task automatic step(input bit r, input bit e, input logic [1:0] md);
    R = r; E = e; MODE = md;
    @(posedge C);
    model_update(r, e, md);
    #1;
    chk("model_sh",   SH,   m_sh);
    chk("model_en",   EN,   m_en);
    chk("model_enp",  ENP,  m_enp);
    chk("model_done", DONE, m_done);
    if (m_cnt_known) chk("model_cnt", CNT, m_cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sh"},   SH,   0);
    chk({tag, "_en"},   EN,   0);
    chk({tag, "_enp"},  ENP,  0);
    chk({tag, "_cnt"},  CNT,  0);
    chk({tag, "_done"}, DONE, 0);
  endtask

  initial begin
    bit          rr, ee;
    logic [1:0]  md;
    R = 1'b1; E = 1'b0; MODE = MODE_FILL;

    // Reset, then FILL
    step(1, 0, MODE_FILL);
    step(1, 0, MODE_FILL);
    chk_zero("reset");
    for (int n = 1; n <= 22; n++) begin
      step(0, 1, MODE_FILL);
      if (n == 1) chk("fill_sh1", SH, 20'h00001);
      if (n == 1 || n == 2) chk("fill_en0", EN[0], n == 2);
      if (n == 6 || n == 7) chk("fill_en1", EN[1], n == 7);
      if (n == 16 || n == 17) chk("fill_en3", EN[3], n == 17);
      if (n >= 19) begin
        chk("fill_done", DONE, n >= 20);
        chk("fill_cnt", CNT, (n >= 20) ? 20 : n);
      end
`ifdef PHASE_EN_GEN_EDGE_EN
      chk("fill_enp1", ENP[1], n == 7);
`else
      chk("enp_off", ENP, 0);
`endif
    end
    step(0, 0, MODE_FILL);
    chk_zero("clear_after_fill");

    // WALK
    for (int n = 1; n <= 25; n++) begin
      step(0, 1, MODE_WALK);
      chk("walk_sh", SH, (n <= 20) ? (32'd1 << (n - 1)) : 32'd0);
      chk("walk_en2", EN[2], n == 12);
      chk("walk_done", DONE, n >= 21);
    end
    step(0, 0, MODE_WALK);

    // RING
    for (int n = 1; n <= 45; n++) begin
      step(0, 1, MODE_RING);
      chk("ring_done", DONE, (n == 21) || (n == 41));
      chk("ring_onehot", $onehot(SH), 1);
      chk("ring_cnt", CNT, n % 20);
    end

    // Reset mid-RING, then restart from bit 0
    step(0, 0, MODE_RING);
    for (int n = 1; n <= 7; n++) step(0, 1, MODE_RING);
    step(1, 1, MODE_RING);
    chk_zero("ring_reset");
    step(0, 1, MODE_RING);
    chk("restart_sh", SH, 20'h00001);
    step(0, 0, MODE_FILL);

    // FILL 8, HOLD 5, FILL to completion
    for (int n = 1; n <= 8; n++) step(0, 1, MODE_FILL);
    for (int n = 1; n <= 5; n++) begin
      step(0, 1, MODE_HOLD);
      chk("hold_sh", SH, 20'h000FF);
      chk("hold_cnt", CNT, 8);
      chk("hold_enp", ENP, 0);
    end
    for (int n = 14; n <= 25; n++) begin
      step(0, 1, MODE_FILL);
      if (n >= 24) chk("hold_fill_done", DONE, n == 25);
    end

    // FILL 10 then E low
    step(0, 0, MODE_FILL);
    for (int n = 1; n <= 10; n++) step(0, 1, MODE_FILL);
    step(0, 0, MODE_FILL);
    chk_zero("e_low");

    // Randomized R/E/MODE with sticky mode
    md = MODE_FILL;
    for (int i = 0; i < 800; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      ee = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) md = 2'($urandom_range(0, 3));
      step(rr, ee, md);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phase_en_gen.md
PHASE_EN_GEN -- requirements
Module: phase_en_gen

Interface
REQ-001 SHALL have parameter LEN, default 20, meaning shift-chain length in bits (LEN >= 2).
REQ-002 SHALL have parameter NCH, default 4, meaning number of enable taps (LEN % NCH == 0, NCH >= 1).
REQ-003 SHALL have port C, input, 1 bit, the single clock; all logic on posedge C.
REQ-004 SHALL have port R, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port E, input, 1 bit, run enable; low clears the chain.
REQ-006 SHALL have port MODE, input, 2 bits: 0 FILL, 1 WALK, 2 RING, 3 HOLD.
REQ-007 SHALL have port SH, output, LEN bits, live shift-chain contents.
REQ-008 SHALL have port EN, output, NCH bits, registered tap enables.
REQ-009 SHALL have port ENP, output, NCH bits, one-cycle rising-edge pulses of EN.
REQ-010 SHALL have port CNT, output, $clog2(LEN+1) bits, step count.
REQ-011 SHALL have port DONE, output, 1 bit, sequence-complete / wrap flag.

Function
REQ-012 SHALL place tap k (k = 0..NCH-1) at chain bit k*LEN/NCH.
REQ-013 SHALL, with E=1, update EN[k] from the pre-shift value of its tap bit, giving one cycle of lag versus SH; in HOLD, EN SHALL retain its value.
REQ-014 FILL SHALL shift in a 1 each edge (SH <= {SH[LEN-2:0],1}); CNT SHALL increment and saturate at LEN; DONE SHALL be set on the edge at which SH becomes all ones, and SHALL then stay set.
REQ-015 WALK SHALL inject a single 1 at bit 0 when SH==0 and DONE==0, and SHALL otherwise shift in 0s; DONE SHALL be set on the edge at which the 1 leaves bit LEN-1, and no re-injection SHALL occur while DONE=1.
REQ-016 RING SHALL inject a 1 at bit 0 when SH==0, and SHALL otherwise rotate left with bit LEN-1 wrapping to bit 0; CNT SHALL wrap modulo LEN; DONE SHALL be a one-cycle pulse on each wrap.
REQ-017 HOLD SHALL freeze SH, CNT, DONE and EN; ENP SHALL be 0.
REQ-018 A MODE change while E=1 SHALL take effect at the next edge and retain SH, CNT and DONE, except that DONE SHALL be cleared on a change into RING.
REQ-019 E=0 SHALL clear SH, EN, ENP, CNT and DONE at the next edge, regardless of MODE.
REQ-020 ENP[k] SHALL equal EN[k] & ~EN_prev[k], registered, asserting on the same edge as the EN rise.
REQ-021 E rising with R=1 on the same edge SHALL give reset priority.

Reset
REQ-022 R=1 SHALL set SH=0, EN=0, ENP=0, CNT=0 and DONE=0 at the next posedge C; R SHALL override E and MODE.
REQ-023 Reset mid-sequence SHALL abandon the sequence, and the first E=1 edge after release SHALL start it from bit 0.

Configuration
REQ-024 Macro PHASE_EN_GEN_EDGE_EN, when defined, SHALL compile in the ENP edge-detect logic per REQ-020.
REQ-025 Without PHASE_EN_GEN_EDGE_EN, ENP SHALL be tied to 0, the EN_prev registers SHALL be absent, and the port SHALL remain present.

Structure
REQ-026 Shared package phase_en_pkg SHALL hold the MODE enum (MODE_FILL, MODE_WALK, MODE_RING, MODE_HOLD) and the tap-index function.
REQ-027 Sub-module phase_en_tap SHALL implement one tap (EN register plus optional edge detect) and SHALL be instantiated NCH times in a generate loop.

Verification (LEN=20, NCH=4, taps 0/5/10/15)
REQ-028 R=1 for 2 cycles, then E=1 in FILL from edge 1 -> SH=0x00001 after edge 1; EN[0] at edge 2; EN[1] at edge 7; EN[3] at edge 17; DONE=1 and CNT=20 at edge 20, stable afterwards.
REQ-029 WALK, E=1 for 25 edges -> SH one-hot advancing each edge; EN[2] high only at edge 12; DONE=1 from edge 21; SH stays 0 afterwards.
REQ-030 RING, E=1 for 45 edges -> DONE pulses at edges 21 and 41; CNT wraps 19 -> 0; SH always one-hot after edge 1.
REQ-031 FILL for 8 edges, HOLD for 5, then FILL -> SH=0x000FF and CNT=8 frozen during HOLD with ENP=0; DONE at edge 25.
REQ-032 FILL for 10 edges, then E=0 for 1 edge -> all outputs 0 at the next edge; R=1 asserted mid-RING -> all outputs 0 at the next edge.
REQ-033 With PHASE_EN_GEN_EDGE_EN defined, FILL -> ENP[1] high only at edge 7; without the macro, ENP==0 for the whole run.
